// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encoding,
// timebase divider and prescaler width helpers.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  // Board cycles per TICK.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to count 0..div-1 (at least 1).
  function automatic int unsigned presc_width(input int unsigned div);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < div) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and control outputs of the stopwatch control stage.
// slave: the controller; master: whatever drives the buttons and consumes
// TICK/CLR_OUT/RUNNING/FREEZE.
interface stopwatch_ctrl_if;
  logic BTN_SS;
  logic BTN_CLR;
  logic BTN_LAP;
  logic TICK;
  logic CLR_OUT;
  logic RUNNING;
  logic FREEZE;

  modport master (
    output BTN_SS, BTN_CLR, BTN_LAP,
    input  TICK, CLR_OUT, RUNNING, FREEZE
  );

  modport slave (
    input  BTN_SS, BTN_CLR, BTN_LAP,
    output TICK, CLR_OUT, RUNNING, FREEZE
  );
endinterface

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop synchronizer followed by a stability counter.
// LEVEL follows the synchronized input once it has been seen DEB_CYCLES
// consecutive times at the new value; PRESS pulses for one cycle when LEVEL
// rises. Stable input to PRESS latency is DEB_CYCLES+2 cycles.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic LEVEL,
  output logic PRESS
);

  localparam int unsigned CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchronize, then count consecutive samples that disagree with LEVEL.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      LEVEL <= 1'b0;
      PRESS <= 1'b0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
      PRESS <= 1'b0;
      if (sync2 == LEVEL) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        LEVEL <= sync2;
        PRESS <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and timebase: debounced start/stop and clear buttons,
// IDLE/RUN/PAUSE state machine, prescaler producing one TICK per
// CLK_HZ/TICK_HZ cycles while running, and CLR_OUT for the counter chain.
// Optional lap/freeze support is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TICK_HZ    = 1,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input logic             CLK,
  input logic             RST,
  stopwatch_ctrl_if.slave sw
);

  localparam int unsigned   DIV        = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned   PW         = presc_width(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  sw_state_t     state;
  logic [PW-1:0] presc;
  logic          tick;
  logic          clr_out;
  logic          running;
  logic          ss_press;
  logic          clr_press;
  logic          ss_level_unused;
  logic          clr_level_unused;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .CLK   (CLK),
    .RST   (RST),
    .BTN   (sw.BTN_SS),
    .LEVEL (ss_level_unused),
    .PRESS (ss_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .CLK   (CLK),
    .RST   (RST),
    .BTN   (sw.BTN_CLR),
    .LEVEL (clr_level_unused),
    .PRESS (clr_press)
  );

`ifdef STOPWATCH_LAP_EN
  logic lap_press;
  logic lap_level_unused;
  logic freeze;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .CLK   (CLK),
    .RST   (RST),
    .BTN   (sw.BTN_LAP),
    .LEVEL (lap_level_unused),
    .PRESS (lap_press)
  );

  assign sw.FREEZE = freeze;
`else
  logic btn_lap_unused;
  assign btn_lap_unused = sw.BTN_LAP;
  assign sw.FREEZE      = 1'b0;
`endif

  // State machine and prescaler; all outputs registered. The prescaler only
  // advances when RUN is kept, so the cycle that leaves RUN never ticks and
  // the fractional second survives a pause.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      presc   <= '0;
      tick    <= 1'b0;
      clr_out <= 1'b1;
      running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      freeze  <= 1'b0;
`endif
    end else begin
      tick    <= 1'b0;
      clr_out <= 1'b0;
      case (state)
        IDLE: begin
          presc <= '0;
`ifdef STOPWATCH_LAP_EN
          freeze <= 1'b0;
`endif
          if (clr_press) begin
            clr_out <= 1'b1;
          end else if (ss_press) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
`ifdef STOPWATCH_LAP_EN
          if (lap_press) freeze <= ~freeze;
`endif
          if (ss_press) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (presc == PRESC_LAST) begin
            presc <= '0;
            tick  <= 1'b1;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        PAUSE: begin
          if (clr_press) begin
            state   <= IDLE;
            presc   <= '0;
            clr_out <= 1'b1;
`ifdef STOPWATCH_LAP_EN
            freeze  <= 1'b0;
`endif
          end else if (ss_press) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          presc   <= '0;
          running <= 1'b0;
        end
      endcase
    end
  end

  assign sw.TICK    = tick;
  assign sw.CLR_OUT = clr_out;
  assign sw.RUNNING = running;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Upstream control and timebase stage of the stopwatch. Debounces the start/stop and clear buttons and runs the IDLE/RUN/PAUSE state machine. Divides the board clock into a one-cycle TICK per second, which drives the units-of-seconds counter. Also issues CLR_OUT to zero the counter chain.

Parameters:
CLK_HZ, 50000000, board clock frequency in Hz.
TICK_HZ, 1, TICK rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer and at least 2.
DEB_CYCLES, 1000000, number of consecutive stable synchronized samples required to accept a button level (20 ms at 50 MHz).

Ports:
CLK  in  1  board clock; the only clock.
RST  in  1  synchronous reset, active-high.
BTN_SS  in  1  start/stop button, asynchronous, active-high.
BTN_CLR  in  1  clear button, asynchronous, active-high.
BTN_LAP  in  1  lap button, asynchronous, active-high; used only with LAP_EN.
TICK  out  1  one-CLK-cycle pulse per elapsed 1/TICK_HZ while running; the seconds stage counts on its rising edge.
CLR_OUT  out  1  clear pulse to the counter chain.
RUNNING  out  1  high in RUN.
FREEZE  out  1  display-hold request (LAP_EN only).

Behaviour:
- Reset (RST high at a CLK edge): state = IDLE, prescaler = 0, TICK = 0, RUNNING = 0, FREEZE = 0, debouncer state cleared.
- CLR_OUT reads 1 while RST is high, then 0 from the first cycle after release. This clears the downstream chain at power-up.
- Debounce: each button passes through a 2-flop synchronizer, then a stability counter.
  - The accepted level changes after DEB_CYCLES consecutive equal samples.
  - A rising edge of the accepted level produces a 1-cycle press pulse.
  - Total latency from a stable input to the press pulse is DEB_CYCLES+2 cycles.
  - Glitches shorter than DEB_CYCLES are ignored.
- FSM transitions take effect on the cycle after the press pulse:
  - IDLE: SS press -> RUN; CLR press -> IDLE with CLR_OUT pulsed for 1 cycle.
  - RUN: SS press -> PAUSE; CLR press is ignored.
  - PAUSE: SS press -> RUN; CLR press -> IDLE with CLR_OUT pulsed and prescaler = 0.
  - SS and CLR pressed in the same cycle: in RUN, SS wins (-> PAUSE); in IDLE or PAUSE, CLR wins.
- Prescaler: width clog2(DIV).
  - Increments only in RUN.
  - At DIV-1 it wraps to 0 and TICK = 1 in that same cycle (registered output).
  - Held in PAUSE, so the fractional second is preserved.
  - Forced to 0 in IDLE.
  - First TICK arrives DIV cycles after entering RUN.
  - Consecutive TICKs in uninterrupted RUN are exactly DIV cycles apart.
- TICK is never asserted outside RUN, never in the same cycle as CLR_OUT, and never on the transition cycle into PAUSE.
- RUNNING is a registered decode of state == RUN.
- Reset asserted mid-run: the next cycle matches the post-reset state, and no TICK is emitted.

Optional Feature:
STOPWATCH_LAP_EN.
- Defined:
  - A BTN_LAP press in RUN toggles FREEZE; counting and TICK continue unaffected. Downstream display latches hold their value while FREEZE = 1.
  - Leaving RUN to PAUSE keeps FREEZE unchanged.
  - IDLE forces FREEZE = 0.
  - A BTN_LAP press in PAUSE or IDLE is ignored.
  - A third debouncer instance is used.
- Undefined: FREEZE tied to 0, BTN_LAP unused, no third debouncer.

Decomposition:
- Shared package/include stopwatch_pkg: state encoding (IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2), the DIV computation, and the prescaler width function.
- One sub-module, btn_debounce (parameter DEB_CYCLES; ports CLK, RST, BTN, LEVEL, PRESS), instantiated once per button.
- FSM and prescaler live in stopwatch_ctrl.

Test Plan:
All scenarios use CLK_HZ = 10, TICK_HZ = 1, DEB_CYCLES = 3.
1. Reset for 2 cycles, then release -> CLR_OUT = 1 during reset and 0 after; TICK = 0; RUNNING = 0; state IDLE.
2. Hold BTN_SS for 6 cycles -> RUNNING rises 6 cycles after the press start (5-cycle debounce latency + 1). Then TICK pulses at 10, 20 and 30 cycles after RUNNING rises, each 1 cycle wide.
3. In RUN, press SS 4 cycles after a TICK, then press SS again -> no TICK during PAUSE. After re-entering RUN, the first TICK comes 6 cycles later (prescaler resumed from 4).
4. 2-cycle BTN_SS glitch in IDLE -> no state change, RUNNING stays 0.
5. In RUN press CLR -> ignored. Then, in PAUSE, press SS and CLR together -> IDLE, one 1-cycle CLR_OUT, prescaler reads 0.
6. With STOPWATCH_LAP_EN, in RUN press LAP twice -> FREEZE goes 1 then 0 and TICK cadence is unchanged. Press LAP in PAUSE -> FREEZE unchanged.
